// File: rtl/mem_pkg.sv
// Shared load/store definitions: size encodings, FSM state set and the
// lane extract/merge helpers used by the syncram initiator.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } state_t;

    function automatic logic access_err(input logic [1:0] addr_lo, input logic [1:0] size);
        return (size == SZ_ILLEGAL) ||
               ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*addr_lo +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{24{b[7] & ~is_unsigned}}, b};
            SZ_HALF: return {{16{h[15] & ~is_unsigned}}, h};
            SZ_WORD: return word;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  addr_lo,
                                               input logic [1:0]  size);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[8*addr_lo +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) r[31:16] = wdata[15:0];
                else            r[15:0]  = wdata[15:0];
            end
            SZ_WORD: r = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/syncram_initiator_if.sv
// Request/response handshake plus word-only syncram port of the initiator.
// slave = the initiator itself, master = CPU datapath and RAM side.
interface syncram_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               resp_ready, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               resp_ready, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/syncram_initiator_lane.sv
// Combinational lane extract (loads) and merge (sub-word store RMW) wrapper.
module syncram_initiator_lane
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    assign rdata  = lane_extract(word, addr_lo, size, is_unsigned);
    assign merged = lane_merge(word, wdata, addr_lo, size);
endmodule

// File: rtl/syncram_initiator.sv
// Load/store initiator for a word-only syncram; sub-word stores are read-modify-write.
// Optional completion counters enabled by SYNCRAM_INITIATOR_STATS_EN.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// READ     | one-cycle mem_cs/mem_oe strobe
// WAIT     | counting down RD_LAT, capture mem_dout at count 1
// WRITE    | one-cycle mem_cs/mem_we strobe
// RESP     | resp_valid held until resp_ready
module syncram_initiator
    import mem_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] BASE_MASK = 32'hFFFF_FFFC
) (
    input  logic              clk,
    input  logic              rst,
    syncram_initiator_if.slave bus,
    output logic              busy,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errs
);
    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [1:0]  cap_addr_lo;
    logic [31:0] cap_wdata;
    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    // Lanes are taken straight from mem_dout on the capture edge so the
    // write data and load result register in the same cycle the word arrives.
    syncram_initiator_lane u_lane (
        .word        (bus.mem_dout),
        .wdata       (cap_wdata),
        .addr_lo     (cap_addr_lo),
        .size        (cap_size),
        .is_unsigned (cap_uns),
        .rdata       (lane_rdata),
        .merged      (lane_merged)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cap_we         <= 1'b0;
            cap_size       <= '0;
            cap_uns        <= 1'b0;
            cap_addr_lo    <= '0;
            cap_wdata      <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_cs     <= 1'b0;
            bus.mem_oe     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_din    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        cap_we        <= bus.req_we;
                        cap_size      <= bus.req_size;
                        cap_uns       <= bus.req_unsigned;
                        cap_addr_lo   <= bus.req_addr[1:0];
                        cap_wdata     <= bus.req_wdata;
                        bus.mem_addr  <= bus.req_addr & BASE_MASK;
                        bus.req_ready <= 1'b0;
                        if (access_err(bus.req_addr[1:0], bus.req_size)) begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            state       <= ST_WRITE;
                            bus.mem_cs  <= 1'b1;
                            bus.mem_we  <= 1'b1;
                            bus.mem_din <= bus.req_wdata;
                        end else begin
                            state      <= ST_READ;
                            bus.mem_cs <= 1'b1;
                            bus.mem_oe <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    bus.mem_cs <= 1'b0;
                    bus.mem_oe <= 1'b0;
                    cnt        <= 4'(RD_LAT);
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (cap_we) begin
                            state       <= ST_WRITE;
                            bus.mem_cs  <= 1'b1;
                            bus.mem_we  <= 1'b1;
                            bus.mem_din <= lane_merged;
                        end else begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b0;
                            bus.resp_rdata <= lane_rdata;
                        end
                    end
                end
                ST_WRITE: begin
                    bus.mem_cs     <= 1'b0;
                    bus.mem_we     <= 1'b0;
                    state          <= ST_RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state          <= ST_IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= '0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SYNCRAM_INITIATOR_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (bus.resp_valid && bus.resp_ready) begin
            if (bus.resp_err)  stat_errs   <= stat_errs + 32'd1;
            else if (cap_we)   stat_stores <= stat_stores + 32'd1;
            else               stat_loads  <= stat_loads + 32'd1;
        end
    end
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_syncram_initiator.sv
// Directed plus randomized bench for syncram_initiator with a 64-word RAM
// model (RD_LAT=1) and an arithmetic reference for lane extract/merge.
module tb_syncram_initiator;
    logic        clk;
    logic        rst;
    logic        busy;
    logic [31:0] stat_loads, stat_stores, stat_errs;

    syncram_initiator_if bus();

    syncram_initiator #(.RD_LAT(1), .BASE_MASK(32'hFFFF_FFFC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
    );

    int checks = 0;
    int errors = 0;
    int n_oe = 0, n_we = 0, n_cs = 0;
    logic [31:0] last_addr, last_din;
    logic [31:0] ram [64];
    logic [31:0] model_ram [64];
    int m_loads = 0, m_stores = 0, m_errs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: data appears one cycle after the oe cycle; writes land on the we edge.
    always @(posedge clk) begin
        if (bus.mem_oe) n_oe++;
        if (bus.mem_we) n_we++;
        if (bus.mem_cs) n_cs++;
        if (bus.mem_cs && bus.mem_oe) begin
            last_addr = bus.mem_addr;
            bus.mem_dout <= ram[bus.mem_addr[7:2]];
        end
        if (bus.mem_cs && bus.mem_we) begin
            last_addr = bus.mem_addr;
            last_din  = bus.mem_din;
            ram[bus.mem_addr[7:2]] = bus.mem_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
        int nb;
        if (sz == 2'b11) return 1'b1;
        nb = nbytes(sz);
        return (a % nb) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
        longint span, v;
        span = longint'(1) << (8 * nbytes(sz));
        v = (longint'(w) >> (8 * (a % 4))) % span;
        if (!u && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [31:0] a, input logic [1:0] sz);
        longint span, mask, r;
        int sh;
        span = longint'(1) << (8 * nbytes(sz));
        sh   = 8 * int'(a % 4);
        mask = (span - 1) << sh;
        r = (longint'(w) & ~mask) | ((longint'(wd) % span) << sh);
        return r[31:0];
    endfunction

    task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input int exp_rd, input int exp_wr, input logic [31:0] exp_din);
        int oe0, we0, cs0, lat;
        @(negedge clk);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
        oe0 = n_oe; we0 = n_we; cs0 = n_cs;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!bus.resp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        repeat (hold) begin @(posedge clk); #1; end
        chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, " resp_rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, " resp_err"}, 32'(bus.resp_err), 32'(exp_err));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({tag, " idle_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " n_read"}, 32'(n_oe - oe0), 32'(exp_rd));
        chk({tag, " n_write"}, 32'(n_we - we0), 32'(exp_wr));
        chk({tag, " n_cs"}, 32'(n_cs - cs0), 32'(exp_rd + exp_wr));
        if (exp_rd + exp_wr > 0) chk({tag, " mem_addr"}, last_addr, a & 32'hFFFF_FFFC);
        if (exp_wr > 0) chk({tag, " mem_din"}, last_din, exp_din);
        if (exp_err) m_errs++;
        else if (we) begin
            m_stores++;
            model_ram[a[7:2]] = m_store(model_ram[a[7:2]], wd, a, sz);
        end else m_loads++;
    endtask

    initial begin
        logic        we, u, e;
        logic [1:0]  sz;
        logic [31:0] a, wd, w, v;
        int          lat, rd, wr;

        rst = 1'b1;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0; bus.mem_dout = 0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ram[i] = v;
            model_ram[i] = v;
        end
        ram[4] = 32'h8899_AABB;
        model_ram[4] = 32'h8899_AABB;
        #12;
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst mem_cs", 32'(bus.mem_cs), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;

        txn("lb_s_12",  0, 2'b00, 0, 32'h12, 0, 0, 32'hFFFF_FF99, 0, 3, 1, 0, 0);
        txn("lh_u_12",  0, 2'b01, 1, 32'h12, 0, 1, 32'h0000_8899, 0, 3, 1, 0, 0);
        txn("lh_s_10",  0, 2'b01, 0, 32'h10, 0, 0, 32'hFFFF_AABB, 0, 3, 1, 0, 0);
        txn("sb_11",    1, 2'b00, 0, 32'h11, 32'h0000_005A, 0, 0, 0, 4, 1, 1, 32'h8899_5ABB);
        txn("lw_10",    0, 2'b10, 1, 32'h10, 0, 0, 32'h8899_5ABB, 0, 3, 1, 0, 0);
        txn("sw_20",    1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, 2, 0, 1, 32'hDEAD_BEEF);
        txn("lh_err13", 0, 2'b01, 0, 32'h13, 0, 5, 0, 1, 1, 0, 0, 0);
        txn("sz11_err", 0, 2'b11, 0, 32'h10, 0, 5, 0, 1, 1, 0, 0, 0);
        txn("sw_restore", 1, 2'b10, 0, 32'h10, 32'h8899_AABB, 0, 0, 0, 2, 0, 1, 32'h8899_AABB);

        // Reset while the 0x11 byte store sits in WAIT.
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b00; bus.req_unsigned = 0;
        bus.req_addr = 32'h11; bus.req_wdata = 32'h5A;
        wr = n_we;
        @(posedge clk); #1; bus.req_valid = 0;
        @(posedge clk); #1;
        chk("abort busy_before", 32'(busy), 32'd1);
        rst = 1'b1; #1;
        chk("abort mem_cs", 32'(bus.mem_cs), 32'd0);
        chk("abort mem_oe", 32'(bus.mem_oe), 32'd0);
        chk("abort mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("abort no_write", 32'(n_we - wr), 32'd0);
        chk("abort word10", ram[4], 32'h8899_AABB);
        chk("abort no_resp", 32'(bus.resp_valid), 32'd0);

        // Reset while mem_oe is high must drop the strobe without a clock edge.
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2'b10; bus.req_addr = 32'h10;
        @(posedge clk); #1; bus.req_valid = 0;
        chk("rd_abort oe_high", 32'(bus.mem_oe), 32'd1);
        rst = 1'b1; #1;
        chk("rd_abort oe_low", 32'(bus.mem_oe), 32'd0);
        chk("rd_abort cs_low", 32'(bus.mem_cs), 32'd0);
        @(negedge clk); rst = 1'b0;
`ifdef SYNCRAM_INITIATOR_STATS_EN
        m_loads = 0; m_stores = 0; m_errs = 0;
`endif

        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            e  = m_err(a, sz);
            w  = model_ram[a[7:2]];
            rd  = (e || (we && sz == 2'b10)) ? 0 : 1;
            wr  = (!e && we) ? 1 : 0;
            lat = e ? 1 : !we ? 3 : (sz == 2'b10) ? 2 : 4;
            txn($sformatf("rnd%0d", i), we, sz, u, a, wd, $urandom_range(0, 3),
                (e || we) ? 32'd0 : m_load(w, a, sz, u), e, lat, rd, wr,
                (sz == 2'b11) ? 32'd0 : m_store(w, wd, a, sz));
        end

        for (int i = 0; i < 64; i++) chk($sformatf("ram_word%0d", i), ram[i], model_ram[i]);

`ifdef SYNCRAM_INITIATOR_STATS_EN
        chk("stat_loads", stat_loads, 32'(m_loads));
        chk("stat_stores", stat_stores, 32'(m_stores));
        chk("stat_errs", stat_errs, 32'(m_errs));
`else
        chk("stat_loads", stat_loads, 32'd0);
        chk("stat_stores", stat_stores, 32'd0);
        chk("stat_errs", stat_errs, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/syncram_initiator.md
Name: syncram_initiator

Overview:
Load/store initiator that drives the word-only syncram port (cs/oe/we/addr/din/dout) on behalf of the CPU datapath.
- Accepts byte/half/word load and store requests over a valid/ready handshake.
- Performs aligned word reads, extracts lanes with sign/zero extension, and returns one response per request.
- Implements sub-word stores as read-modify-write, so the RAM only ever sees full-word writes.

Parameters:
RD_LAT, 1, cycles from the mem_oe cycle to valid mem_dout; legal range 1..15.
BASE_MASK, 32'hFFFF_FFFC, AND-mask applied to req_addr to form mem_addr.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend loads when 1
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  response accepted
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned access or illegal size
busy  out  1  state != IDLE
mem_cs  out  1  RAM chip select
mem_oe  out  1  RAM read strobe
mem_we  out  1  RAM write strobe
mem_addr  out  32  word-aligned RAM address
mem_din  out  32  RAM write data
mem_dout  in  32  RAM read data
stat_loads  out  32  completed loads (see Optional Feature)
stat_stores  out  32  completed stores
stat_errs  out  32  error responses

Behaviour:
Reset:
- State IDLE. All outputs 0 except req_ready=1. Captured request registers cleared.
- Reset asserted mid-operation aborts immediately: mem_cs/oe/we drop asynchronously and no response is issued.

Memory outputs:
- All mem_* outputs are registered (Moore); they never depend on req_* combinationally.

States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: on req_valid&req_ready, capture the request. Next state:
  - illegal size, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP, err=1, no RAM access.
  - word store -> WRITE.
  - otherwise -> READ.
- READ: mem_cs=mem_oe=1, mem_we=0, for exactly one cycle. Load wait counter with RD_LAT. Next state WAIT.
- WAIT: decrement the counter. At count 1, capture mem_dout into rbuf. Then:
  - load -> RESP.
  - sub-word store -> WRITE.
- WRITE: mem_cs=mem_we=1, mem_oe=0, for exactly one cycle. mem_din depends on the store type:
  - word store: req_wdata.
  - byte store: rbuf with lane addr[1:0] replaced by wdata[7:0].
  - half store: rbuf with lane addr[1] replaced by wdata[15:0].
  - Little-endian lanes: byte k = bits [8k+7:8k].
  - Next state RESP.
- RESP: resp_valid=1 and resp_rdata/resp_err stable until resp_ready. On the handshake edge -> IDLE. No new request is accepted in the same cycle.

Load extraction:
- byte: rbuf lane addr[1:0].
- half: rbuf lane addr[1].
- Sign-extend from the lane MSB unless req_unsigned. Word loads ignore req_unsigned.

Latency, counted from the accept edge to the first cycle with resp_valid=1:
- load: 2+RD_LAT
- word store: 2
- sub-word store: 3+RD_LAT
- error: 1

Access rules:
- mem_addr = req_addr & BASE_MASK for the whole transaction.
- No back-to-back overlap: at most one transaction is in flight.

Optional Feature:
SYNCRAM_INITIATOR_STATS_EN.
- Defined: stat_* are 32-bit wrapping counters, incremented on the RESP handshake edge by response type (error -> stat_errs only). Reset to 0.
- Undefined: no counter flops; stat_* tied to 0. Port list is unchanged.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL.
  - state enum.
  - function lane_extract(word, addr_lo, size, unsigned).
  - function lane_merge(word, wdata, addr_lo, size).
- One sub-module: syncram_initiator_lane (combinational extract/merge wrapper around the package functions), instantiated once.

Test Plan:
All scenarios use RAM word 0x10 preset to 0x8899AABB and RD_LAT=1.
- Signed byte load at 0x12 -> resp_rdata=0xFFFFFF99 and resp_err=0; resp_valid 3 cycles after accept; mem_oe high for exactly 1 cycle with mem_addr=0x10.
- Unsigned half load at 0x12 -> 0x00008899. Signed half load at 0x10 -> 0xFFFFAABB.
- Byte store 0x5A to 0x11 -> one read, then one write with mem_din=0x88995ABB; a following word load of 0x10 returns 0x88995ABB.
- Word store 0xDEADBEEF to 0x20 -> mem_we for 1 cycle with mem_din=0xDEADBEEF; mem_oe never asserted; resp_valid 2 cycles after accept.
- Half load at 0x13 or req_size=11 -> resp_err=1 and resp_rdata=0; mem_cs never asserted; resp held for 5 cycles while resp_ready=0, then IDLE.
- rst pulsed during WAIT of the 0x11 byte store -> mem_* go low asynchronously; mem_we never asserted; word 0x10 stays 0x8899AABB; req_ready=1 after reset.
